// File: rtl/my_cpu.sv
// my_cpu: 16-bit five-stage (IF/ID/EX/MEM/WB) load/store core, eight GPRs,
// Harvard instruction/data ports, no interlocks or forwarding.
module my_cpu (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] i_datain,
  input  logic [15:0] d_datain,
  input  logic [3:0]  select_y,
  output logic [7:0]  i_addr,
  output logic [7:0]  d_addr,
  output logic [15:0] d_dataout,
  output logic        d_we,
  output logic [15:0] y
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXEC   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [4:0] OP_HALT = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100, OP_SLA  = 5'b00101, OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111, OP_ADD  = 5'b01000, OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB  = 5'b01010, OP_SUBI = 5'b01011, OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND  = 5'b01101, OP_OR   = 5'b01110, OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH = 5'b10000, OP_ADDC = 5'b10001, OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP = 5'b11000, OP_JMPR = 5'b11001, OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ  = 5'b11011, OP_BN   = 5'b11100, OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC   = 5'b11110, OP_BNC  = 5'b11111;

  logic [1:0]  state_q, state_d;
  logic [7:0]  pc;
  logic [15:0] id_ir, reg_A, reg_B, reg_C, reg_C1, smdr, smdr1;
  logic [15:0] gr [0:7];
  logic [4:0]  ex_op, mem_op, wb_op;
  logic [2:0]  ex_r1, mem_r1, wb_r1;
  logic        zf, nf, cf;

  logic [4:0]  id_op;
  logic        run, take_br, upd, zf_d, nf_d, cf_d, wb_wr;
  logic [15:0] gr_r1, gr_r2, gr_r3, a_d, b_d, alu_y;
  logic [16:0] wide;

  assign id_op     = id_ir[15:11];
  assign gr_r1     = gr[id_ir[10:8]];
  assign gr_r2     = gr[id_ir[6:4]];
  assign gr_r3     = gr[id_ir[2:0]];
  assign i_addr    = pc;
  assign d_addr    = reg_C[7:0];
  assign d_dataout = smdr1;
  assign d_we      = (mem_op == OP_STORE);
  // A HALT sitting in ID stops fetch at once, so pc and id_ir freeze on it.
  assign run       = (state_q == EXEC) && (id_op != OP_HALT);

  // Run-control state: IDLE -> EXEC on start, EXEC -> HALTED on HALT in ID.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start) state_d = EXEC;
    else if (state_q == EXEC && id_op == OP_HALT) state_d = HALTED;
  end

  // Jump/branch decision in MEM; flags still hold the pre-branch result.
  always_comb begin
    case (mem_op)
      OP_JUMP, OP_JMPR: take_br = 1'b1;
      OP_BZ:            take_br = zf;
      OP_BNZ:           take_br = !zf;
      OP_BN:            take_br = nf;
      OP_BNN:           take_br = !nf;
      OP_BC:            take_br = cf;
      OP_BNC:           take_br = !cf;
      default:          take_br = 1'b0;
    endcase
  end

  // ID operand selection: A/B per instruction format.
  always_comb begin
    a_d = gr_r2;
    b_d = gr_r3;
    case (id_op)
      OP_LOAD, OP_STORE, OP_SLL, OP_SLA, OP_SRL, OP_SRA:
        b_d = {12'h000, id_ir[3:0]};
      OP_ADDI, OP_SUBI, OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
        a_d = gr_r1;
        b_d = {8'h00, id_ir[7:0]};
      end
      OP_LDIH: begin
        a_d = gr_r1;
        b_d = {id_ir[7:0], 8'h00};
      end
      OP_JUMP: begin
        a_d = '0;
        b_d = {8'h00, id_ir[7:0]};
      end
      default: ;
    endcase
  end

  // EX ALU and flag update.
  always_comb begin
    alu_y = '0;
    wide  = '0;
    upd   = 1'b0;
    zf_d  = zf;
    nf_d  = nf;
    cf_d  = cf;
    case (ex_op)
      OP_LOAD, OP_STORE, OP_JUMP, OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
        alu_y = reg_A + reg_B;
      OP_SLL, OP_SLA: begin alu_y = reg_A << reg_B[3:0]; cf_d = 1'b0; upd = 1'b1; end
      OP_SRL:         begin alu_y = reg_A >> reg_B[3:0]; cf_d = 1'b0; upd = 1'b1; end
      OP_SRA:         begin alu_y = 16'($signed(reg_A) >>> reg_B[3:0]); cf_d = 1'b0; upd = 1'b1; end
      OP_ADD, OP_ADDI, OP_LDIH, OP_ADDC: begin
        wide  = {1'b0, reg_A} + {1'b0, reg_B} + {16'h0000, (ex_op == OP_ADDC) && cf};
        alu_y = wide[15:0];
        cf_d  = wide[16];
        upd   = 1'b1;
      end
      OP_SUB, OP_SUBI, OP_CMP, OP_SUBC: begin
        wide  = {1'b0, reg_A} - {1'b0, reg_B} - {16'h0000, (ex_op == OP_SUBC) && cf};
        alu_y = wide[15:0];
        cf_d  = wide[16];
        upd   = 1'b1;
      end
      OP_AND: begin alu_y = reg_A & reg_B; cf_d = 1'b0; upd = 1'b1; end
      OP_OR:  begin alu_y = reg_A | reg_B; cf_d = 1'b0; upd = 1'b1; end
      OP_XOR: begin alu_y = reg_A ^ reg_B; cf_d = 1'b0; upd = 1'b1; end
      default: ;
    endcase
    if (upd) begin
      zf_d = (alu_y == 16'h0000);
      nf_d = alu_y[15];
    end
  end

  // WB write enable for register-writing opcodes (gr0 is never written).
  always_comb begin
    case (wb_op)
      OP_LOAD, OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
      OP_AND, OP_OR, OP_XOR, OP_LDIH, OP_ADDC, OP_SUBC: wb_wr = (wb_r1 != 3'd0);
      default: wb_wr = 1'b0;
    endcase
  end

  // Pipeline registers; enable low freezes everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc      <= '0;
      id_ir   <= '0;
      ex_op   <= '0;  ex_r1  <= '0;  mem_op <= '0;  mem_r1 <= '0;
      wb_op   <= '0;  wb_r1  <= '0;
      reg_A   <= '0;  reg_B  <= '0;  reg_C  <= '0;  reg_C1 <= '0;
      smdr    <= '0;  smdr1  <= '0;
      zf      <= 1'b0; nf    <= 1'b0; cf     <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      if (run) begin
        id_ir <= i_datain;
        pc    <= take_br ? reg_C[7:0] : pc + 8'd1;
      end
      ex_op  <= run ? id_op : 5'b00000;
      ex_r1  <= id_ir[10:8];
      reg_A  <= a_d;
      reg_B  <= b_d;
      smdr   <= gr_r1;
      mem_op <= ex_op;
      mem_r1 <= ex_r1;
      reg_C  <= alu_y;
      smdr1  <= smdr;
      zf     <= zf_d;
      nf     <= nf_d;
      cf     <= cf_d;
      wb_op  <= mem_op;
      wb_r1  <= mem_r1;
      reg_C1 <= (mem_op == OP_LOAD) ? d_datain : reg_C;
    end
  end

  // Register file write-back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) gr[i] <= '0;
    end else if (enable && wb_wr) begin
      gr[wb_r1] <= reg_C1;
    end
  end

  // Debug read-out mux.
  always_comb begin
    case (select_y)
      4'd8:    y = {8'h00, pc};
      4'd9:    y = id_ir;
      4'd10:   y = reg_A;
      4'd11:   y = reg_B;
      4'd12:   y = reg_C;
      4'd13:   y = reg_C1;
      4'd14:   y = {13'h0000, zf, nf, cf};
      4'd15:   y = smdr1;
      default: y = gr[select_y[2:0]];
    endcase
  end

endmodule

// File: tb/tb_my_cpu.sv
// Directed bench for my_cpu with behavioural instruction ROM and data RAM.
module tb_my_cpu;

  logic        clock = 1'b0;
  logic        reset, enable, start;
  logic [15:0] i_datain, d_datain, d_dataout, y;
  logic [3:0]  select_y;
  logic [7:0]  i_addr, d_addr;
  logic        d_we;

  logic [15:0] rom [0:255];
  logic [15:0] ram [0:255];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [4:0] NOP = 5'b00000, HALT = 5'b00001, LOAD = 5'b00010, STORE = 5'b00011;
  localparam logic [4:0] ADDI = 5'b01001, SUB = 5'b01010, CMP = 5'b01100;
  localparam logic [4:0] BZ = 5'b11010, BNZ = 5'b11011;

  my_cpu dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .i_datain(i_datain), .d_datain(d_datain), .select_y(select_y),
    .i_addr(i_addr), .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .y(y)
  );

  always #5 clock = ~clock;

  assign i_datain = rom[i_addr];
  assign d_datain = ram[d_addr];
  always @(posedge clock) if (d_we) ram[d_addr] <= d_dataout;

  function automatic logic [15:0] rrr(input logic [4:0] op, input logic [2:0] r1, r2, r3);
    return {op, r1, 1'b0, r2, 1'b0, r3};
  endfunction
  function automatic logic [15:0] rv(input logic [4:0] op, input logic [2:0] r1, r2, input logic [3:0] v);
    return {op, r1, 1'b0, r2, v};
  endfunction
  function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] r1, input logic [7:0] imm);
    return {op, r1, imm};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    enable = 1'b1; start = 1'b0; select_y = 4'd0; reset = 1'b0;
    for (int i = 0; i < 256; i++) begin rom[i] = 16'h0000; ram[i] = 16'h0000; end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // After return the start edge has passed: state EXEC, pc still 0.
  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_halt_drain(input string tag);
    int unsigned cnt = 0;
    while (dut.id_ir[15:11] !== HALT && cnt < 80) begin @(negedge clock); cnt++; end
    check(tag, {15'h0, cnt < 80}, 16'h0001);
    repeat (6) @(negedge clock);
  endtask

  initial begin
    int unsigned cnt;

    // ---- reset state ----
    do_reset();
    check("rst_i_addr", {8'h0, i_addr}, 16'h0000);
    check("rst_y_gr0", y, 16'h0000);
    check("rst_d_we", {15'h0, d_we}, 16'h0000);

    // ---- program 1: loads, SUB, STORE, HALT ----
    rom[0]  = rv(LOAD, 3'd1, 3'd0, 4'd0);
    rom[1]  = rv(LOAD, 3'd2, 3'd0, 4'd1);
    rom[5]  = rrr(SUB, 3'd3, 3'd1, 3'd2);
    rom[9]  = rv(STORE, 3'd3, 3'd0, 4'd2);
    rom[10] = {HALT, 11'h000};
    ram[0]  = 16'h3CAB;
    ram[1]  = 16'h3C00;
    do_start();
    cnt = 0;
    while (d_we !== 1'b1 && cnt < 40) begin @(negedge clock); cnt++; end
    check("store_seen", {15'h0, cnt < 40}, 16'h0001);
    check("store_d_addr", {8'h0, d_addr}, 16'h0002);
    check("store_d_dataout", d_dataout, 16'h00AB);
    @(negedge clock);
    check("store_we_one_cycle", {15'h0, d_we}, 16'h0000);
    repeat (6) @(negedge clock);
    check("p1_gr1", dut.gr[1], 16'h3CAB);
    check("p1_gr2", dut.gr[2], 16'h3C00);
    check("p1_gr3", dut.gr[3], 16'h00AB);
    check("p1_ram2", ram[2], 16'h00AB);
    select_y = 4'd14; #1;
    check("p1_flags", y, 16'h0000);
    check("p1_pc_halt", {8'h0, dut.pc}, 16'h000B);
    check("p1_id_ir_halt", dut.id_ir, {HALT, 11'h000});
    start = 1'b1; repeat (3) @(negedge clock); start = 1'b0; repeat (3) @(negedge clock);
    check("p1_no_resume", {8'h0, i_addr}, 16'h000B);

    // ---- program 2: ADDI carry into high byte, SUB equal -> zf ----
    do_reset();
    rom[0] = ri(ADDI, 3'd1, 8'hFF);
    rom[4] = ri(ADDI, 3'd1, 8'h01);
    rom[8] = rrr(SUB, 3'd2, 3'd1, 3'd1);
    rom[9] = {HALT, 11'h000};
    do_start();
    wait_halt_drain("p2_halt");
    select_y = 4'd1; #1;
    check("p2_y_gr1", y, 16'h0100);
    check("p2_gr2", dut.gr[2], 16'h0000);
    select_y = 4'd14; #1;
    check("p2_flags_zf", y, 16'h0004);
    select_y = 4'd8; #1;
    check("p2_y_pc", y, 16'h000A);

    // ---- program 3: CMP 0-1 -> nf, cf ----
    do_reset();
    rom[0] = ri(ADDI, 3'd1, 8'h01);
    rom[4] = rrr(CMP, 3'd0, 3'd0, 3'd1);
    rom[5] = {HALT, 11'h000};
    do_start();
    wait_halt_drain("p3_halt");
    select_y = 4'd14; #1;
    check("p3_flags_nf_cf", y, 16'h0003);
    check("p3_gr1", dut.gr[1], 16'h0001);
    check("p3_gr0", dut.gr[0], 16'h0000);

    // ---- program 4: BZ taken ----
    do_reset();
    rom[0]     = rrr(SUB, 3'd2, 3'd0, 3'd0);
    rom[1]     = ri(BZ, 3'd1, 8'h20);
    rom[5]     = ri(ADDI, 3'd4, 8'h66);
    rom[6]     = {HALT, 11'h000};
    rom[8'h20] = ri(ADDI, 3'd3, 8'h55);
    rom[8'h21] = {HALT, 11'h000};
    do_start();
    cnt = 0;
    while (i_addr !== 8'h20 && cnt < 12) begin @(negedge clock); cnt++; end
    check("bz_i_addr_20", {8'h0, i_addr}, 16'h0020);
    wait_halt_drain("p4_halt");
    check("bz_gr3", dut.gr[3], 16'h0055);
    check("bz_gr4", dut.gr[4], 16'h0000);
    check("bz_pc", {8'h0, dut.pc}, 16'h0022);

    // ---- program 5: BNZ not taken ----
    do_reset();
    rom[0]     = rrr(SUB, 3'd2, 3'd0, 3'd0);
    rom[1]     = ri(BNZ, 3'd1, 8'h20);
    rom[5]     = ri(ADDI, 3'd4, 8'h66);
    rom[6]     = {HALT, 11'h000};
    rom[8'h20] = ri(ADDI, 3'd3, 8'h55);
    rom[8'h21] = {HALT, 11'h000};
    do_start();
    wait_halt_drain("p5_halt");
    check("bnz_gr4", dut.gr[4], 16'h0066);
    check("bnz_gr3", dut.gr[3], 16'h0000);
    check("bnz_pc", {8'h0, dut.pc}, 16'h0007);

    // ---- program 6: enable freeze, then reset mid-run ----
    do_reset();
    rom[0] = ri(ADDI, 3'd1, 8'h11);
    rom[5] = ri(ADDI, 3'd2, 8'h22);
    do_start();
    repeat (6) @(negedge clock);
    check("run_pc6", {8'h0, i_addr}, 16'h0006);
    check("run_gr1", dut.gr[1], 16'h0011);
    enable = 1'b0;
    repeat (5) @(negedge clock);
    check("frz_pc", {8'h0, i_addr}, 16'h0006);
    check("frz_gr2", dut.gr[2], 16'h0000);
    enable = 1'b1;
    repeat (4) @(negedge clock);
    check("resume_gr2", dut.gr[2], 16'h0022);
    check("resume_pc", {8'h0, i_addr}, 16'h000A);
    select_y = 4'd1;
    #1 reset = 1'b0;
    #1;
    check("mrst_i_addr", {8'h0, i_addr}, 16'h0000);
    check("mrst_d_addr", {8'h0, d_addr}, 16'h0000);
    check("mrst_d_dataout", d_dataout, 16'h0000);
    check("mrst_d_we", {15'h0, d_we}, 16'h0000);
    check("mrst_y_gr1", y, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_pc", {8'h0, i_addr}, 16'h0000);
    check("idle_id_ir", dut.id_ir, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
